// File: rtl/online_arith_pkg.sv
// online_arith_pkg: shared radix/digit constants and helpers for the online arithmetic datapath
//   Provides default sizing (digits, radix, digit width), LOG2_RADIX and result-width
//   derivation, legal digit bounds, the digit_legal() check and the converter FSM state type.
package online_arith_pkg;
    localparam int DEF_NO_OF_DIGITS = 8;
    localparam int DEF_RADIX_BITS   = 3;
    localparam int DEF_RADIX        = 4;
    function automatic int log2_radix(input int radix);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) == radix) ? i : r;
        return r;
    endfunction
    function automatic int out_width(input int n, input int radix);
        return n * log2_radix(radix) + 1;
    endfunction
    localparam int DEF_LOG2_RADIX = log2_radix(DEF_RADIX);
    localparam int DEF_OUT_W      = out_width(DEF_NO_OF_DIGITS, DEF_RADIX);
    localparam int DIGIT_MAX      = DEF_RADIX - 1;
    localparam int DIGIT_MIN      = -(DEF_RADIX - 1);
    function automatic logic digit_legal(input int d, input int radix);
        return (d <= radix - 1) && (d >= -(radix - 1));
    endfunction
    typedef enum logic {ACCUM, DONE} conv_state_t;
endpackage

// File: rtl/otf_digit_update.sv
// otf_digit_update: one combinational step of on-the-fly conversion (Q/QM update)
//   i_q, i_qm : current Q and QM (QM = Q-1), signed OUT_W
//   i_d       : incoming signed digit, RADIX_BITS wide
//   o_q, o_qm : updated Q' = RADIX*Q + d and QM' = Q' - 1
module otf_digit_update #(
    parameter int OUT_W      = 17,
    parameter int LOG2_RADIX = 2,
    parameter int RADIX_BITS = 3
) (
    input  logic signed [OUT_W-1:0]      i_q,
    input  logic signed [OUT_W-1:0]      i_qm,
    input  logic        [RADIX_BITS-1:0] i_d,
    output logic signed [OUT_W-1:0]      o_q,
    output logic signed [OUT_W-1:0]      o_qm
);
    localparam logic signed [OUT_W-1:0] RADIX_W = OUT_W'(1) << LOG2_RADIX;
    localparam logic signed [OUT_W-1:0] ONE     = OUT_W'(1);
    logic signed [OUT_W-1:0] w_d, w_rq, w_rqm;
    logic                    w_neg, w_pos;
    assign w_d   = OUT_W'($signed(i_d));
    assign w_rq  = i_q <<< LOG2_RADIX;
    assign w_rqm = i_qm <<< LOG2_RADIX;
    assign w_neg = w_d[OUT_W-1];
    assign w_pos = !w_neg && (w_d != '0);
    // Negative digits borrow from QM so no carry ripples through the word.
    assign o_q  = w_neg ? w_rqm + RADIX_W + w_d : w_rq + w_d;
    assign o_qm = w_pos ? w_rq + w_d - ONE : w_rqm + RADIX_W - ONE + w_d;
endmodule

// File: rtl/online_to_binary_converter.sv
// online_to_binary_converter: MSD-first radix-RADIX digit stream to two's-complement word
//   clk, rst (async, active-high)
//   digit_in/digit_valid/digit_ready   : signed digit input handshake, MSD first
//   result/result_valid/result_ready   : converted OUT_W-bit word handshake
//   digit_err                          : illegal digit seen in this word, qualified by result_valid
module online_to_binary_converter
    import online_arith_pkg::*;
#(
    parameter int NO_OF_DIGITS = DEF_NO_OF_DIGITS,
    parameter int RADIX_BITS   = DEF_RADIX_BITS,
    parameter int RADIX        = DEF_RADIX
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [RADIX_BITS-1:0]                           digit_in,
    input  logic                                            digit_valid,
    output logic                                            digit_ready,
    output logic [NO_OF_DIGITS*log2_radix(RADIX):0]         result,
    output logic                                            result_valid,
    input  logic                                            result_ready,
    output logic                                            digit_err
);
    localparam int LOG2_RADIX = log2_radix(RADIX);
    localparam int OUT_W      = out_width(NO_OF_DIGITS, RADIX);
    localparam int CNT_W      = (NO_OF_DIGITS > 1) ? $clog2(NO_OF_DIGITS) : 1;
    conv_state_t             r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [OUT_W-1:0] r_q, r_qm, w_q_next, w_qm_next;
    logic [OUT_W-1:0]        r_result;
    logic                    r_err, r_err_out, w_err_next, w_accept, w_last;
    otf_digit_update #(
        .OUT_W     (OUT_W),
        .LOG2_RADIX(LOG2_RADIX),
        .RADIX_BITS(RADIX_BITS)
    ) u_otf (
        .i_q (r_q),
        .i_qm(r_qm),
        .i_d (digit_in),
        .o_q (w_q_next),
        .o_qm(w_qm_next)
    );
    assign w_accept   = digit_valid && digit_ready;
    assign w_last     = r_cnt == CNT_W'(NO_OF_DIGITS - 1);
    assign w_err_next = r_err || !digit_legal(int'($signed(digit_in)), RADIX);
    assign result     = r_result;
    assign digit_err  = r_err_out;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_next;
    end
    // result_valid is exactly the DONE state, so an async reset drops it at once.
    always_comb begin
        digit_ready  = r_state == ACCUM;
        result_valid = r_state == DONE;
        w_state_next = (r_state == ACCUM) ? ((w_accept && w_last) ? DONE : ACCUM)
                                          : (result_ready ? ACCUM : DONE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_qm      <= '1;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_err_out <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            r_q   <= w_last ? '0 : w_q_next;
            r_qm  <= w_last ? '1 : w_qm_next;
            r_err <= w_last ? 1'b0 : w_err_next;
            if (w_last) begin
                r_result  <= w_q_next;
                r_err_out <= w_err_next;
            end
        end
    end
endmodule

// File: tb/tb_online_to_binary_converter.sv
// tb_online_to_binary_converter: directed self-checking bench for the on-the-fly converter
module tb_online_to_binary_converter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  digit_in = 3'd0;
    logic        digit_valid = 1'b0;
    logic        digit_ready;
    logic [16:0] result;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic        digit_err;
    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    online_to_binary_converter dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Digits packed as octal, MSD first (3=3, -3=5, 1=1, -1=7, 2=2, -2=6, -4=4).
    task automatic run_word(input string tag, input logic [23:0] dv, input logic [16:0] exp_res,
                            input logic exp_err, input int stall, input bit keep);
        int first;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            digit_in    = dv[23-3*i -: 3];
            digit_valid = 1'b1;
            for (int k = 0; k < 20 && !digit_ready; k++) step();
            chk({tag, "_rdy"}, 32'(digit_ready), 32'd1);
            if (i == 0) first = cyc;
            step();
        end
        digit_in = 3'o3;
        chk({tag, "_valid"}, 32'(result_valid), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_err"}, 32'(digit_err), 32'(exp_err));
        chk({tag, "_latency"}, 32'(cyc - first), 32'd8);
        chk({tag, "_busy"}, 32'(digit_ready), 32'd0);
        if (stall > 0) begin
            result_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                step();
                chk({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
                chk({tag, "_hold_result"}, 32'(result), 32'(exp_res));
                chk({tag, "_hold_busy"}, 32'(digit_ready), 32'd0);
            end
        end
        if (!keep) begin
            result_ready = 1'b1;
            step();
            chk({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(digit_ready), 32'd1);
        end
    endtask

    initial begin
        #3;
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(digit_err), 32'd0);
        #9 rst = 1'b0;
        step();
        chk("rst_ready", 32'(digit_ready), 32'd1);

        run_word("max_pos", 24'o33333333, 17'd65535, 1'b0, 0, 1'b0);
        run_word("max_neg", 24'o55555555, 17'h10001, 1'b0, 0, 1'b0);
        run_word("qm_path", 24'o17000000, 17'd12288, 1'b0, 0, 1'b0);
        run_word("minus_one", 24'o00000007, 17'h1FFFF, 1'b0, 0, 1'b0);
        run_word("zero", 24'o00000000, 17'd0, 1'b0, 0, 1'b0);
        run_word("stall", 24'o25106371, 17'd21421, 1'b0, 5, 1'b0);
        run_word("bad_digit", 24'o10040000, 17'd15360, 1'b1, 0, 1'b0);
        run_word("clean_after_err", 24'o33333333, 17'd65535, 1'b0, 0, 1'b0);

        digit_valid = 1'b1;
        digit_in    = 3'o1;
        for (int i = 0; i < 4; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_ready", 32'(digit_ready), 32'd1);
        rst = 1'b0;
        run_word("after_abort", 24'o33333333, 17'd65535, 1'b0, 0, 1'b0);

        run_word("done_rst", 24'o17000000, 17'd12288, 1'b0, 1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("done_rst_valid", 32'(result_valid), 32'd0);
        chk("done_rst_ready", 32'(digit_ready), 32'd1);
        rst = 1'b0;
        result_ready = 1'b1;
        run_word("after_done_rst", 24'o00000007, 17'h1FFFF, 1'b0, 0, 1'b0);

        digit_valid = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
